grant_arbiter: RTL and testbench

Round-robin arbiter sharing one downstream resource among up to 16 requesters. Each requester raises a level request; the block issues a registered one-hot grant plus its binary index to the resource mux, holds it until the requester releases or a hold limit expires with competitors waiting, then rotates priority. The index output uses the one-hot-to-binary mapping of the team's encoder: bit i maps to i, no grant maps to 0.

---
 rtl/grant_arbiter_if.sv | 13 +
 rtl/grant_arbiter.sv | 75 +++++++
 tb/tb_grant_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/grant_arbiter_if.sv
// grant_arbiter_if: request/grant bundle between requesters (master) and the arbiter (slave)
interface grant_arbiter_if #(
  parameter int NUM_REQ = 16,
  parameter int IDX_BITS = 4
);
  logic enable;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_BITS-1:0] grant_idx;
  logic grant_valid;
  modport master (output enable, req, input grant, grant_idx, grant_valid);
  modport slave (input enable, req, output grant, grant_idx, grant_valid);
endinterface

// File: rtl/grant_arbiter.sv
// grant_arbiter: round-robin arbiter with hold limit, one-cycle turnaround gap and registered one-hot/binary grant
module grant_arbiter #(
  parameter int NUM_REQ = 16,
  parameter int IDX_BITS = 4,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst_n,
  grant_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic [IDX_BITS-1:0] idx, idx_n, last, last_n, win, p;
  logic [7:0] cnt, cnt_n;
  logic valid, found, holder, others, limit;
  always_comb begin
    found = 1'b0;
    win = '0;
    p = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      p = IDX_BITS'((int'(last) + 1 + k) % NUM_REQ);
      if (!found && bus.req[p]) begin
        found = 1'b1;
        win = p;
      end
    end
  end
  assign holder = bus.req[idx];
  assign others = |(bus.req & ~grant);
  // a holder that has used its full allowance yields to any competitor, even a late one
  assign limit = cnt >= 8'(MAX_HOLD - 1);
  always_comb begin
    state_n = state;
    grant_n = grant;
    idx_n = idx;
    last_n = last;
    cnt_n = (state == GRANT && cnt != 8'(MAX_HOLD)) ? cnt + 8'd1 : cnt;
    if (state == GRANT) begin
      if (!holder || (others && limit)) begin
        state_n = GAP;
        grant_n = '0;
        idx_n = '0;
      end
    end else if (bus.enable && found) begin
      state_n = GRANT;
      grant_n = NUM_REQ'(1) << win;
      idx_n = win;
      last_n = win;
      cnt_n = '0;
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      idx <= '0;
      valid <= 1'b0;
      cnt <= '0;
      last <= IDX_BITS'(NUM_REQ - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      idx <= idx_n;
      valid <= state_n == GRANT;
      cnt <= cnt_n;
      last <= last_n;
    end
  end
  assign bus.grant = grant;
  assign bus.grant_idx = idx;
  assign bus.grant_valid = valid;
endmodule

// File: tb/tb_grant_arbiter.sv
// tb_grant_arbiter: directed scoreboard bench for grant_arbiter (NUM_REQ=16, MAX_HOLD=8)
module tb_grant_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  grant_arbiter_if #(.NUM_REQ(16), .IDX_BITS(4)) bus ();
  grant_arbiter #(.NUM_REQ(16), .IDX_BITS(4), .MAX_HOLD(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    string tag;
    int idx;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  // drive one cycle of inputs, queue the grant expected after the edge (-1 = none), then compare
  task automatic step(input string tag, input logic [15:0] r, input logic e, input logic rn, input int g);
    exp_t x;
    logic [15:0] eg;
    logic [3:0] ei;
    logic ev;
    bus.req = r;
    bus.enable = e;
    rst_n = rn;
    sb.push_back('{tag, g});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    eg = (x.idx < 0) ? 16'h0 : 16'h1 << x.idx;
    ei = (x.idx < 0) ? 4'd0 : 4'(x.idx);
    ev = x.idx >= 0;
    checks += 3;
    assert (bus.grant === eg) else begin
      errors++;
      $error("FAIL %s grant got %h exp %h", x.tag, bus.grant, eg);
    end
    assert (bus.grant_idx === ei) else begin
      errors++;
      $error("FAIL %s grant_idx got %0d exp %0d", x.tag, bus.grant_idx, ei);
    end
    assert (bus.grant_valid === ev) else begin
      errors++;
      $error("FAIL %s grant_valid got %b exp %b", x.tag, bus.grant_valid, ev);
    end
  endtask
  initial begin
    bus.req = '0;
    bus.enable = 1'b1;
    step("reset", 16'h0000, 1, 0, -1);
    step("reset", 16'h0000, 1, 0, -1);
    for (int i = 0; i < 3; i++) step("single", 16'h0020, 1, 1, 5);
    step("single_gap", 16'h0000, 1, 1, -1);
    step("single_idle", 16'h0000, 1, 1, -1);
    step("rr_reset", 16'h0000, 1, 0, -1);
    step("rr_0", 16'h8003, 1, 1, 0);
    step("rr_0", 16'h8003, 1, 1, 0);
    step("rr_gap", 16'h8002, 1, 1, -1);
    step("rr_1", 16'h8003, 1, 1, 1);
    step("rr_1", 16'h8003, 1, 1, 1);
    step("rr_gap", 16'h8001, 1, 1, -1);
    step("rr_15", 16'h8003, 1, 1, 15);
    step("rr_15", 16'h8003, 1, 1, 15);
    step("rr_gap", 16'h0003, 1, 1, -1);
    step("rr_0b", 16'h8003, 1, 1, 0);
    step("rr_end_gap", 16'h0000, 1, 1, -1);
    step("rr_end_idle", 16'h0000, 1, 1, -1);
    for (int i = 0; i < 3; i++) step("pre_3", 16'h0008, 1, 1, 3);
    for (int i = 0; i < 5; i++) step("pre_3", 16'h0088, 1, 1, 3);
    step("pre_gap", 16'h0088, 1, 1, -1);
    step("pre_7", 16'h0088, 1, 1, 7);
    step("pre_7", 16'h0088, 1, 1, 7);
    step("pre_rel_gap", 16'h0008, 1, 1, -1);
    step("pre_3_again", 16'h0008, 1, 1, 3);
    step("pre_end_gap", 16'h0000, 1, 1, -1);
    step("pre_end_idle", 16'h0000, 1, 1, -1);
    for (int i = 0; i < 40; i++) step("alone", 16'h0004, 1, 1, 2);
    step("en_hold", 16'h0004, 0, 1, 2);
    step("en_gap", 16'h0200, 0, 1, -1);
    step("en_idle", 16'h0200, 0, 1, -1);
    step("en_idle", 16'h0200, 0, 1, -1);
    step("en_9", 16'h0200, 1, 1, 9);
    step("rst_gap", 16'h1000, 1, 1, -1);
    step("rst_12", 16'h1000, 1, 1, 12);
    step("rst_12", 16'h1001, 1, 1, 12);
    step("rst_mid", 16'h1001, 1, 0, -1);
    step("rst_after", 16'h1001, 1, 1, 0);
    step("rst_after", 16'h1001, 1, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
